// File: rtl/mm_pkg.sv
// Shared definitions for mm_result_streamer.
//   state_t      : controller states
//   DEF_*        : default configuration (8x8 result of 8-bit elements, 1024-cycle timeout)
//   idx_width    : width of a counter/index covering n values, never less than 1 bit
//   elem_offset  : bit offset of flat element idx inside the packed result
package mm_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StWait,
        StStream
    } state_t;

    localparam int unsigned DEF_DATA_WIDTH = 8;
    localparam int unsigned DEF_M          = 8;
    localparam int unsigned DEF_P          = 8;
    localparam int unsigned DEF_TIMEOUT    = 1024;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic int unsigned elem_offset(input int unsigned idx, input int unsigned width);
        return idx * width;
    endfunction

endpackage

// File: rtl/mm_wait_timer.sv
// Loadable up-counter used to bound the wait for mm_done.
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : load the counter with 0 (wins over en)
//   en         : count up by one this cycle
//   expired    : counter equals TIMEOUT-1; never asserts when TIMEOUT is 0
module mm_wait_timer
    import mm_pkg::*;
#(
    parameter int unsigned TIMEOUT = DEF_TIMEOUT,
    parameter int unsigned CNT_W   = idx_width(TIMEOUT)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic en,
    output logic expired
);

    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (en) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // TIMEOUT == 0 disables expiry; the counter may wrap harmlessly in that case.
    assign expired = (TIMEOUT != 0) && (count_q == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/mm_result_streamer.sv
// Host-side controller for a matrix multiplier's start/done/packed-result interface.
// A go pulse issues a one-cycle mm_start, waits (bounded) for mm_done, captures
// mm_result and streams the M*P elements row-major over valid/ready.
//   clk, rst_n       : clock, asynchronous active-low reset
//   go               : host request, only honoured when idle
//   busy             : job in progress
//   err              : one-cycle pulse when the wait for mm_done times out
//   mm_start         : one-cycle start pulse to the multiplier
//   mm_done          : multiplier done (pulse or level), only looked at while waiting
//   mm_result        : packed result, element (r,c) at [(r*P+c)*DATA_WIDTH +: DATA_WIDTH]
//   out_valid/ready  : output handshake
//   out_data         : element value
//   out_row, out_col : element coordinates
//   out_last_col     : beat is the last column of its row
//   out_last         : beat is the final element
module mm_result_streamer
    import mm_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned M          = DEF_M,
    parameter int unsigned P          = DEF_P,
    parameter int unsigned TIMEOUT    = DEF_TIMEOUT
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         go,
    output logic                         busy,
    output logic                         err,
    output logic                         mm_start,
    input  logic                         mm_done,
    input  logic [M*P*DATA_WIDTH-1:0]    mm_result,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [DATA_WIDTH-1:0]        out_data,
    output logic [idx_width(M)-1:0]      out_row,
    output logic [idx_width(P)-1:0]      out_col,
    output logic                         out_last_col,
    output logic                         out_last
);

    localparam int unsigned NUM   = M * P;
    localparam int unsigned IDX_W = idx_width(NUM);
    localparam int unsigned ROW_W = idx_width(M);
    localparam int unsigned COL_W = idx_width(P);
    localparam int unsigned CNT_W = idx_width(TIMEOUT);

    state_t state_q, state_d;

    logic [NUM*DATA_WIDTH-1:0] capture_q;
    logic [IDX_W-1:0]          index_q;
    logic [ROW_W-1:0]          row_q;
    logic [COL_W-1:0]          col_q;

    logic timer_clear, timer_en, timer_expired;
    logic capture_en;
    logic handshake, is_last_col, is_last;

    mm_wait_timer #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) u_wait_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (timer_clear),
        .en      (timer_en),
        .expired (timer_expired)
    );

    assign is_last_col = (col_q == COL_W'(P - 1));
    assign is_last     = is_last_col && (row_q == ROW_W'(M - 1));
    assign handshake   = out_valid && out_ready;

    // Outputs decode straight from the state register so an asynchronous reset
    // drops busy/mm_start/out_valid immediately.
    always_comb begin
        state_d     = state_q;
        timer_clear = 1'b0;
        timer_en    = 1'b0;
        capture_en  = 1'b0;
        busy        = (state_q != StIdle);
        mm_start    = 1'b0;
        err         = 1'b0;
        out_valid   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (go) begin
                    state_d = StStart;
                end
            end
            StStart: begin
                mm_start    = 1'b1;
                timer_clear = 1'b1;
                state_d     = StWait;
            end
            StWait: begin
                timer_en = 1'b1;
                // done beats a coincident timeout
                if (mm_done) begin
                    capture_en = 1'b1;
                    state_d    = StStream;
                end else if (timer_expired) begin
                    err     = 1'b1;
                    state_d = StIdle;
                end
            end
            StStream: begin
                out_valid = 1'b1;
                if (out_ready && is_last) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            capture_q <= '0;
            index_q   <= '0;
            row_q     <= '0;
            col_q     <= '0;
        end else if (capture_en) begin
            capture_q <= mm_result;
            index_q   <= '0;
            row_q     <= '0;
            col_q     <= '0;
        end else if (handshake) begin
            if (is_last) begin
                index_q <= '0;
                row_q   <= '0;
                col_q   <= '0;
            end else begin
                index_q <= index_q + IDX_W'(1);
                if (is_last_col) begin
                    col_q <= '0;
                    row_q <= row_q + ROW_W'(1);
                end else begin
                    col_q <= col_q + COL_W'(1);
                end
            end
        end
    end

    assign out_data     = capture_q[elem_offset(32'(index_q), DATA_WIDTH) +: DATA_WIDTH];
    assign out_row      = row_q;
    assign out_col      = col_q;
    assign out_last_col = out_valid && is_last_col;
    assign out_last     = out_valid && is_last;

endmodule

// File: tb/tb_mm_result_streamer.sv
`timescale 1ns/1ps
module tb_mm_result_streamer;

    localparam int DW = 8;
    localparam int M  = 8;
    localparam int P  = 8;
    localparam int N  = M * P;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // main instance (default TIMEOUT)
    logic          go = 1'b0, mm_done = 1'b0, out_ready = 1'b1;
    logic [N*DW-1:0] mm_result = '0;
    logic          busy, err, mm_start, out_valid, out_last_col, out_last;
    logic [DW-1:0] out_data;
    logic [2:0]    out_row, out_col;

    // short-timeout instance
    logic          go2 = 1'b0, mm_done2 = 1'b0;
    logic [N*DW-1:0] mm_result2 = '0;
    logic          busy2, err2, mm_start2, out_valid2, out_last_col2, out_last2;
    logic [DW-1:0] out_data2;
    logic [2:0]    out_row2, out_col2;

    mm_result_streamer #(.DATA_WIDTH(DW), .M(M), .P(P)) dut (
        .clk(clk), .rst_n(rst_n), .go(go), .busy(busy), .err(err), .mm_start(mm_start),
        .mm_done(mm_done), .mm_result(mm_result), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_row(out_row), .out_col(out_col),
        .out_last_col(out_last_col), .out_last(out_last)
    );

    mm_result_streamer #(.DATA_WIDTH(DW), .M(M), .P(P), .TIMEOUT(16)) dut2 (
        .clk(clk), .rst_n(rst_n), .go(go2), .busy(busy2), .err(err2), .mm_start(mm_start2),
        .mm_done(mm_done2), .mm_result(mm_result2), .out_valid(out_valid2), .out_ready(1'b1),
        .out_data(out_data2), .out_row(out_row2), .out_col(out_col2),
        .out_last_col(out_last_col2), .out_last(out_last2)
    );

    int total = 0;
    int bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic fail(input string name);
        total++;
        bad++;
        $display("FAIL %s actual=missing required=present (t=%0t)", name, $time);
    endtask

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [7:0] data;
        logic [2:0] row;
        logic [2:0] col;
        logic       lc;
        logic       l;
    } beat_t;

    beat_t exp_q[$];
    logic [7:0] pat [N];

    task automatic push_expected();
        beat_t e;
        for (int k = 0; k < N; k++) begin
            e.data = pat[k];
            e.row  = 3'(k / P);
            e.col  = 3'(k % P);
            e.lc   = ((k % P) == P - 1);
            e.l    = (k == N - 1);
            exp_q.push_back(e);
        end
    endtask

    int beats = 0;
    bit stalled = 0;
    logic [15:0] held;

    always @(negedge clk) begin
        beat_t e;
        logic [15:0] now;
        now = {out_data, out_row, out_col, out_last_col, out_last};
        if (!rst_n) begin
            stalled = 0;
        end else begin
            if (stalled && out_valid) check("stall_hold", now, held);
            stalled = out_valid && !out_ready;
            held = now;
            if (out_valid && out_ready) begin
                beats++;
                if (exp_q.size() == 0) begin
                    fail("expected_beat_for_unexpected_output");
                end else begin
                    e = exp_q.pop_front();
                    check("beat", now, {e.data, e.row, e.col, e.lc, e.l});
                end
            end
        end
    end

    // multiplier stand-in for the main instance
    int  starts = 0;
    int  done_delay = 20;
    bit  hold_done = 0;
    bit  overwrite = 0;

    always @(negedge clk) if (rst_n && mm_start) starts++;

    initial begin : standin
        forever begin
            @(negedge clk);
            if (rst_n && mm_start) begin
                for (int k = 0; k < N; k++) mm_result[k*DW +: DW] = pat[k];
                repeat (done_delay) @(posedge clk);
                #1 mm_done = 1'b1;
                @(posedge clk);
                #1;
                if (!hold_done) mm_done = 1'b0;
                if (overwrite) mm_result = '1;
            end
        end
    end

    // downstream ready: 0 = always, 1 = 1,0,0,1 repeating, 2 = random
    int ready_mode = 0;
    int rphase = 0;
    initial begin : ready_drv
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0: out_ready = 1'b1;
                1: begin
                    out_ready = ((rphase % 4) == 0) || ((rphase % 4) == 3);
                    rphase++;
                end
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // monitor for the short-timeout instance; its result element k is k
    int s2 = 0, e2 = 0, err2_cnt = 0, beats2 = 0;
    bit err2_prev = 0;
    always @(negedge clk) begin
        logic [7:0] k8;
        if (rst_n) begin
            if (err2_prev) check("busy_after_timeout", busy2, 0);
            err2_prev = err2;
            if (mm_start2) s2 = cyc;
            if (err2) begin
                err2_cnt++;
                e2 = cyc;
            end
            if (out_valid2) begin
                k8 = beats2[7:0];
                check("to_beat", {out_data2, out_last2}, {k8, beats2 == N - 1});
                beats2++;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic pulse_go();
        @(posedge clk);
        #1 go = 1'b1;
        @(posedge clk);
        #1 go = 1'b0;
    endtask

    task automatic pulse_go2();
        @(posedge clk);
        #1 go2 = 1'b1;
        @(posedge clk);
        #1 go2 = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        bit ok;
        ok = 0;
        for (int i = 0; i < 3000 && !ok; i++) begin
            @(negedge clk);
            if (!busy) ok = 1;
        end
        if (!ok) fail(name);
    endtask

    task automatic run_job(input int extra_gos);
        int base;
        beats = 0;
        base = starts;
        push_expected();
        pulse_go();
        check("start_timing", {mm_start, busy}, 2'b11);
        for (int i = 0; i < extra_gos; i++) begin
            repeat (7) @(posedge clk);
            pulse_go();
        end
        wait_idle("job_idle_bound");
        check("beat_count", beats, N);
        check("start_count", starts - base, 1);
        check("left_in_queue", exp_q.size(), 0);
        check("busy_after", busy, 0);
    endtask

    task automatic random_pat();
        for (int k = 0; k < N; k++) pat[k] = 8'($urandom);
    endtask

    initial begin : main
        bit ok;
        for (int k = 0; k < N; k++) mm_result2[k*DW +: DW] = 8'(k);
        for (int k = 0; k < N; k++) pat[k] = 8'(k);

        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs",
              {busy, err, mm_start, out_valid, out_data, out_row, out_col, out_last_col, out_last},
              '0);
        check("reset_outputs2", {busy2, err2, mm_start2, out_valid2}, '0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // basic stream, then with 1,0,0,1 backpressure
        run_job(0);
        ready_mode = 1;
        rphase = 0;
        run_job(0);

        // random data with a signed extreme, repeated go while busy, result clobbered after done
        ready_mode = 2;
        random_pat();
        pat[5] = 8'h80;
        overwrite = 1;
        run_job(5);
        overwrite = 0;

        // leave done held high across idle, then a fresh job must still start and capture new data
        ready_mode = 0;
        random_pat();
        hold_done = 1;
        run_job(0);
        repeat (20) @(posedge clk);
        hold_done = 0;
        ready_mode = 2;
        random_pat();
        run_job(0);
        repeat (25) @(posedge clk);

        // asynchronous reset mid-stream
        ready_mode = 0;
        random_pat();
        beats = 0;
        push_expected();
        pulse_go();
        ok = 0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (beats >= 10) ok = 1;
        end
        if (!ok) fail("reach_beat10_bound");
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1 check("async_reset_drop", {busy, out_valid, mm_start}, 3'b000);
        exp_q.delete();
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        random_pat();
        run_job(0);

        // timeout with done never arriving
        err2_cnt = 0;
        beats2 = 0;
        pulse_go2();
        ok = 0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (!busy2) ok = 1;
        end
        if (!ok) fail("timeout_idle_bound");
        check("timeout_err_count", err2_cnt, 1);
        check("timeout_err_cycle", e2 - s2, 16);
        check("timeout_no_beats", beats2, 0);

        // done on the expiry cycle wins
        pulse_go2();
        repeat (16) @(posedge clk);
        #1 mm_done2 = 1'b1;
        @(posedge clk);
        #1 mm_done2 = 1'b0;
        ok = 0;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clk);
            if (!busy2) ok = 1;
        end
        if (!ok) fail("coincide_idle_bound");
        check("coincide_err_count", err2_cnt, 1);
        check("coincide_beats", beats2, N);

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
